// File: rtl/sparse_dot_sequencer_if.sv
// ============================================================================
//  Module      : sparse_dot_sequencer_if
//  Description : Operand streams, FP16 unit and result bus for the sparse
//                dot-product sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sparse_dot_sequencer_if #(
    parameter int IDX_W = 8
);
    logic             a_valid;
    logic             a_ready;
    logic [IDX_W-1:0] a_idx;
    logic [15:0]      a_val;
    logic             a_last;

    logic             b_valid;
    logic             b_ready;
    logic [IDX_W-1:0] b_idx;
    logic [15:0]      b_val;
    logic             b_last;

    logic             mul_en;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [15:0]      mul_res;
    logic             mul_ovf;
    logic             mul_unf;
    logic             mul_nan;

    logic             add_en;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_res;
    logic             add_ovf;
    logic             add_unf;

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [2:0]       res_flags;

    // Sequencer side
    modport master (
        input  a_valid, a_idx, a_val, a_last,
        input  b_valid, b_idx, b_val, b_last,
        output a_ready, b_ready,
        output mul_en, mul_a, mul_b,
        input  mul_res, mul_ovf, mul_unf, mul_nan,
        output add_en, add_a, add_b,
        input  add_res, add_ovf, add_unf,
        output res_valid, res_data, res_flags,
        input  res_ready
    );

    // Stream sources, FPU units and result consumer
    modport slave (
        output a_valid, a_idx, a_val, a_last,
        output b_valid, b_idx, b_val, b_last,
        input  a_ready, b_ready,
        input  mul_en, mul_a, mul_b,
        output mul_res, mul_ovf, mul_unf, mul_nan,
        input  add_en, add_a, add_b,
        output add_res, add_ovf, add_unf,
        input  res_valid, res_data, res_flags,
        output res_ready
    );
endinterface

`default_nettype wire

// File: rtl/sparse_dot_sequencer.sv
// ============================================================================
//  Module      : sparse_dot_sequencer
//  Description : Merge-joins two index-sorted sparse streams and sequences the
//                shared FP16 mult/adder to accumulate one dot product.
//                Optional macro SPDOT_MATCH_CNT_EN adds the o_match_cnt output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sparse_dot_sequencer #(
    parameter int IDX_W   = 8,
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    output logic                  o_busy,
`ifdef SPDOT_MATCH_CNT_EN
    output logic [CNT_W-1:0]      o_match_cnt,
`endif
    sparse_dot_sequencer_if.master bus
);

    localparam int c_LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int c_LAT_W   = $clog2(c_LAT_MAX + 1);
    localparam logic [c_LAT_W-1:0] c_MUL_LAST = c_LAT_W'(MUL_LAT - 1);
    localparam logic [c_LAT_W-1:0] c_ADD_LAST = c_LAT_W'(ADD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMP      = 3'd1,
        S_MUL_WAIT = 3'd2,
        S_ADD_WAIT = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [15:0]          r_acc;
    logic [2:0]           r_flags;
    logic                 r_a_done;
    logic                 r_b_done;
    logic [15:0]          r_mul_a;
    logic [15:0]          r_mul_b;
    logic [15:0]          r_add_b;
    logic [c_LAT_W-1:0]   r_lat;

    logic                 w_a_ready;
    logic                 w_b_ready;
    logic                 w_match;
    logic                 w_mul_en;
    logic                 w_add_en;
    logic                 w_mul_last;
    logic                 w_add_last;
    logic                 w_a_pop;
    logic                 w_b_pop;
    logic [IDX_W-1:0]     w_a_idx;
    logic [IDX_W-1:0]     w_b_idx;

    // Illegal parameterisations leave this marker in the elaborated hierarchy.
    if (MUL_LAT < 1 || ADD_LAT < 1 || CNT_W < 1) begin : g_bad_params
    end

    assign w_a_idx    = bus.a_idx;
    assign w_b_idx    = bus.b_idx;
    assign w_a_pop    = bus.a_valid & w_a_ready;
    assign w_b_pop    = bus.b_valid & w_b_ready;
    assign w_mul_last = (r_lat == c_MUL_LAST);
    assign w_add_last = (r_lat == c_ADD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_match      = 1'b0;
        w_mul_en     = 1'b0;
        w_add_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_CMP;
                end
            end
            S_CMP: begin
                if (r_a_done && r_b_done) begin
                    w_next_state = S_DONE;
                end else if (r_a_done || r_b_done) begin
                    w_next_state = S_DRAIN;
                end else if (bus.a_valid && bus.b_valid) begin
                    if (w_a_idx < w_b_idx) begin
                        w_a_ready = 1'b1;
                    end else if (w_a_idx > w_b_idx) begin
                        w_b_ready = 1'b1;
                    end else begin
                        w_a_ready    = 1'b1;
                        w_b_ready    = 1'b1;
                        w_match      = 1'b1;
                        w_next_state = S_MUL_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                w_mul_en = 1'b1;
                if (w_mul_last) begin
                    w_next_state = S_ADD_WAIT;
                end
            end
            S_ADD_WAIT: begin
                w_add_en = 1'b1;
                if (w_add_last) begin
                    w_next_state = S_CMP;
                end
            end
            S_DRAIN: begin
                // Discard the tail of whichever stream has not yet seen its last.
                if (r_a_done) begin
                    w_b_ready = 1'b1;
                    if (bus.b_valid && bus.b_last) begin
                        w_next_state = S_DONE;
                    end
                end else begin
                    w_a_ready = 1'b1;
                    if (bus.a_valid && bus.a_last) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 16'h0000;
            r_flags  <= 3'b000;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_mul_a  <= 16'h0000;
            r_mul_b  <= 16'h0000;
            r_add_b  <= 16'h0000;
            r_lat    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc    <= 16'h0000;
                        r_flags  <= 3'b000;
                        r_a_done <= 1'b0;
                        r_b_done <= 1'b0;
                    end
                end
                S_CMP, S_DRAIN: begin
                    if (w_a_pop && bus.a_last) begin
                        r_a_done <= 1'b1;
                    end
                    if (w_b_pop && bus.b_last) begin
                        r_b_done <= 1'b1;
                    end
                    if (w_match) begin
                        r_mul_a <= bus.a_val;
                        r_mul_b <= bus.b_val;
                    end
                    r_lat <= '0;
                end
                S_MUL_WAIT: begin
                    if (w_mul_last) begin
                        r_add_b <= bus.mul_res;
                        r_flags <= r_flags | {bus.mul_nan, bus.mul_unf, bus.mul_ovf};
                        r_lat   <= '0;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_ADD_WAIT: begin
                    if (w_add_last) begin
                        r_acc   <= bus.add_res;
                        r_flags <= r_flags | {1'b0, bus.add_unf, bus.add_ovf};
                        r_lat   <= '0;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPDOT_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_match_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_match_cnt <= '0;
        end else if (r_state == S_ADD_WAIT && w_add_last && r_match_cnt != c_CNT_MAX) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign o_match_cnt = r_match_cnt;
`endif

    assign o_busy        = (r_state != S_IDLE);
    assign bus.a_ready   = w_a_ready;
    assign bus.b_ready   = w_b_ready;
    assign bus.mul_en    = w_mul_en;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.add_en    = w_add_en;
    assign bus.add_a     = r_acc;
    assign bus.add_b     = r_add_b;
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_data  = (r_state == S_DONE) ? r_acc : 16'h0000;
    assign bus.res_flags = (r_state == S_DONE) ? r_flags : 3'b000;

endmodule

`default_nettype wire

// File: tb/tb_sparse_dot_sequencer.sv
// ============================================================================
//  Module      : tb_sparse_dot_sequencer
//  Description : Directed self-checking bench for sparse_dot_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sparse_dot_sequencer;
    localparam int IDX_W   = 8;
    localparam int MUL_LAT = 3;
    localparam int ADD_LAT = 3;
    localparam int CNT_W   = 8;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic busy;
    logic force_ovf = 1'b0;
`ifdef SPDOT_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sparse_dot_sequencer_if #(.IDX_W(IDX_W)) bus_if ();

    sparse_dot_sequencer #(
        .IDX_W  (IDX_W),
        .MUL_LAT(MUL_LAT),
        .ADD_LAT(ADD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .o_busy     (busy),
`ifdef SPDOT_MATCH_CNT_EN
        .o_match_cnt(match_cnt),
`endif
        .bus        (bus_if)
    );

    // Stream sources: tables are armed by tasks, consumption counted here.
    logic [IDX_W-1:0] a_idx_tab [8];
    logic [15:0]      a_val_tab [8];
    logic [IDX_W-1:0] b_idx_tab [8];
    logic [15:0]      b_val_tab [8];
    int a_len = 0, a_base = 0, a_pops = 0;
    int b_len = 0, b_base = 0, b_pops = 0;
    int a_pos, b_pos;

    always_comb begin
        a_pos = a_pops - a_base;
        b_pos = b_pops - b_base;
        bus_if.a_valid = 1'b0; bus_if.a_idx = '0; bus_if.a_val = '0; bus_if.a_last = 1'b0;
        bus_if.b_valid = 1'b0; bus_if.b_idx = '0; bus_if.b_val = '0; bus_if.b_last = 1'b0;
        if (a_pos >= 0 && a_pos < a_len) begin
            bus_if.a_valid = 1'b1;
            bus_if.a_idx   = a_idx_tab[a_pos];
            bus_if.a_val   = a_val_tab[a_pos];
            bus_if.a_last  = (a_pos == a_len - 1);
        end
        if (b_pos >= 0 && b_pos < b_len) begin
            bus_if.b_valid = 1'b1;
            bus_if.b_idx   = b_idx_tab[b_pos];
            bus_if.b_val   = b_val_tab[b_pos];
            bus_if.b_last  = (b_pos == b_len - 1);
        end
    end

    always @(posedge clk) begin
        if (bus_if.a_valid && bus_if.a_ready) a_pops <= a_pops + 1;
        if (bus_if.b_valid && bus_if.b_ready) b_pops <= b_pops + 1;
    end

    // FPU models: result is only meaningful on the final enabled cycle.
    int mul_cnt, add_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= 0;
            add_cnt <= 0;
        end else begin
            mul_cnt <= bus_if.mul_en ? mul_cnt + 1 : 0;
            add_cnt <= bus_if.add_en ? add_cnt + 1 : 0;
        end
    end

    always_comb begin
        bus_if.mul_res = 16'hDEAD;
        bus_if.mul_ovf = 1'b0;
        bus_if.mul_unf = 1'b0;
        bus_if.mul_nan = 1'b0;
        if (bus_if.mul_en && mul_cnt == MUL_LAT - 1) begin
            case ({bus_if.mul_a, bus_if.mul_b})
                32'h4000_4200: bus_if.mul_res = 16'h4600;
                32'h4000_4000: bus_if.mul_res = 16'h4400;
                default:       bus_if.mul_res = 16'hDEAD;
            endcase
            bus_if.mul_ovf = force_ovf;
        end
    end

    always_comb begin
        bus_if.add_res = 16'hBEEF;
        bus_if.add_ovf = 1'b0;
        bus_if.add_unf = 1'b0;
        if (bus_if.add_en && add_cnt == ADD_LAT - 1) begin
            case ({bus_if.add_a, bus_if.add_b})
                32'h0000_4600: bus_if.add_res = 16'h4600;
                32'h0000_4400: bus_if.add_res = 16'h4400;
                32'h4400_4400: bus_if.add_res = 16'h4800;
                32'h4800_4400: bus_if.add_res = 16'h4A00;
                default:       bus_if.add_res = 16'hBEEF;
            endcase
        end
    end

    // mul_en burst monitor
    int mul_cycles = 0, bursts = 0, bad_bursts = 0, run_len = 0;
    always @(posedge clk) begin
        if (bus_if.mul_en) begin
            run_len    <= run_len + 1;
            mul_cycles <= mul_cycles + 1;
        end else begin
            if (run_len != 0) begin
                bursts <= bursts + 1;
                if (run_len != MUL_LAT) bad_bursts <= bad_bursts + 1;
            end
            run_len <= 0;
        end
    end

    initial bus_if.res_ready = 1'b0;

    task automatic arm_streams(input int na, input int nb);
        a_base = a_pops;
        b_base = b_pops;
        a_len  = na;
        b_len  = nb;
    endtask

    task automatic load_case1;
        a_idx_tab[0] = 8'd1; a_val_tab[0] = 16'h3C00;
        a_idx_tab[1] = 8'd3; a_val_tab[1] = 16'h4000;
        b_idx_tab[0] = 8'd3; b_val_tab[0] = 16'h4200;
        b_idx_tab[1] = 8'd5; b_val_tab[1] = 16'h4000;
        arm_streams(2, 2);
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_result(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (bus_if.res_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic accept_result;
        @(negedge clk) bus_if.res_ready = 1'b1;
        @(negedge clk) bus_if.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, bus_if.a_ready, bus_if.b_ready, bus_if.mul_en, bus_if.add_en, bus_if.res_valid,
             bus_if.mul_a, bus_if.mul_b, bus_if.add_a, bus_if.add_b, bus_if.res_data,
             bus_if.res_flags} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b res_valid=%b mul_en=%b res_data=%h, required all zero",
                     busy, bus_if.res_valid, bus_if.mul_en, bus_if.res_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic_match;
        int  cyc;
        bit  seen;
        load_case1();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end
        wait_result(100, cyc, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL basic_timeout: res_valid=0 after %0d cycles, required 1", cyc);
        end
        n_checks++;
        if (bus_if.res_data !== 16'h4600) begin
            n_fail++;
            $display("FAIL basic_data: got %h required 4600", bus_if.res_data);
        end
        n_checks++;
        if (bus_if.res_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_flags: got %b required 000", bus_if.res_flags);
        end
`ifdef SPDOT_MATCH_CNT_EN
        n_checks++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_match_cnt: got %0d required 1", match_cnt);
        end
`endif
        accept_result();
        n_checks++;
        if (busy !== 1'b0 || bus_if.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: busy=%b res_valid=%b required 0 0", busy, bus_if.res_valid);
        end
    endtask

    task automatic test_no_match;
        int cyc;
        bit seen;
        int mul_before;
        a_idx_tab[0] = 8'd0; a_val_tab[0] = 16'h3C00;
        a_idx_tab[1] = 8'd2; a_val_tab[1] = 16'h3C00;
        b_idx_tab[0] = 8'd1; b_val_tab[0] = 16'h3C00;
        b_idx_tab[1] = 8'd3; b_val_tab[1] = 16'h3C00;
        arm_streams(2, 2);
        mul_before = mul_cycles;
        pulse_start();
        wait_result(20, cyc, seen);
        n_checks++;
        if (!seen || cyc > 5) begin
            n_fail++;
            $display("FAIL nomatch_latency: res_valid=%b after %0d cycles, required 1 within 5", seen, cyc);
        end
        n_checks++;
        if (bus_if.res_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL nomatch_data: got %h required 0000", bus_if.res_data);
        end
        n_checks++;
        if (mul_cycles != mul_before) begin
            n_fail++;
            $display("FAIL nomatch_mul_en: %0d mul_en cycles, required 0", mul_cycles - mul_before);
        end
        n_checks++;
        if (bus_if.res_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL nomatch_flags: got %b required 000", bus_if.res_flags);
        end
        accept_result();
    endtask

    task automatic test_all_match;
        int cyc;
        bit seen;
        int bursts_before, bad_before;
        for (int i = 0; i < 3; i++) begin
            a_idx_tab[i] = 8'(i); a_val_tab[i] = 16'h4000;
            b_idx_tab[i] = 8'(i); b_val_tab[i] = 16'h4000;
        end
        arm_streams(3, 3);
        bursts_before = bursts;
        bad_before    = bad_bursts;
        pulse_start();
        wait_result(200, cyc, seen);
        n_checks++;
        if (!seen || bus_if.res_data !== 16'h4A00) begin
            n_fail++;
            $display("FAIL allmatch_data: valid=%b got %h required 4A00", seen, bus_if.res_data);
        end
        n_checks++;
        if (bursts - bursts_before != 3) begin
            n_fail++;
            $display("FAIL allmatch_bursts: got %0d required 3", bursts - bursts_before);
        end
        n_checks++;
        if (bad_bursts != bad_before) begin
            n_fail++;
            $display("FAIL allmatch_burst_len: %0d bursts not %0d cycles long, required 0",
                     bad_bursts - bad_before, MUL_LAT);
        end
`ifdef SPDOT_MATCH_CNT_EN
        n_checks++;
        if (match_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL allmatch_match_cnt: got %0d required 3", match_cnt);
        end
`endif
        accept_result();
    endtask

    task automatic test_hold;
        int cyc;
        bit seen;
        load_case1();
        pulse_start();
        wait_result(100, cyc, seen);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3);
            n_checks++;
            if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 16'h4600 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h busy=%b required 1 4600 1",
                         i, bus_if.res_valid, bus_if.res_data, busy);
            end
        end
        start = 1'b0;
        accept_result();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_start_ignored: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit seen;
        load_case1();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.mul_en === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_no_mul_wait: mul_en=0 after 20 cycles, required 1");
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, bus_if.a_ready, bus_if.b_ready, bus_if.mul_en, bus_if.add_en, bus_if.res_valid,
             bus_if.mul_a, bus_if.mul_b, bus_if.add_a, bus_if.add_b, bus_if.res_data,
             bus_if.res_flags} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b mul_en=%b mul_a=%h mul_b=%h, required all zero",
                     busy, bus_if.mul_en, bus_if.mul_a, bus_if.mul_b);
        end
        @(negedge clk) rst_n = 1'b1;
        load_case1();
        pulse_start();
        wait_result(100, cyc, seen);
        n_checks++;
        if (!seen || bus_if.res_data !== 16'h4600) begin
            n_fail++;
            $display("FAIL midreset_rerun: valid=%b got %h required 4600", seen, bus_if.res_data);
        end
        accept_result();
    endtask

    task automatic test_flags;
        int cyc;
        bit seen;
        force_ovf = 1'b1;
        load_case1();
        pulse_start();
        wait_result(100, cyc, seen);
        n_checks++;
        if (!seen || bus_if.res_flags !== 3'b001) begin
            n_fail++;
            $display("FAIL ovf_flag: valid=%b got %b required 001", seen, bus_if.res_flags);
        end
        n_checks++;
        if (bus_if.res_data !== 16'h4600) begin
            n_fail++;
            $display("FAIL ovf_data: got %h required 4600", bus_if.res_data);
        end
        force_ovf = 1'b0;
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_no_match();
        test_all_match();
        test_hold();
        test_reset_mid();
        test_flags();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
